pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single 256-bit physical memory port between two cacheline clients:
//   port 0 is the instruction cache, port 1 is the data cache.
//  Sits between both cache instances (pmem_* side) and physical memory.
//  Grants one whole line transaction at a time; round-robin on contention.
//  Latches the winner's command so pmem sees a stable request for the whole transaction.
// PARAMETERS
//  s_line      256  cacheline width in bits (pmem_rdata/pmem_wdata width)
//  s_addr      32   address width
//  RR_INIT     0    client favoured on the first contended grant after reset
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       reset; asynchronous assert, active-low; clears all state
//  c0_address   in   s_addr  client0 line address (held by client until c0_resp)
//  c0_read      in   1       client0 line read request
//  c0_write     in   1       client0 line write request
//  c0_wdata     in   s_line  client0 write line
//  c0_rdata     out  s_line  read line to client0 (= pmem_rdata, unregistered)
//  c0_resp      out  1       client0 transaction complete, 1-cycle pulse
//  c1_*         ...          identical set for client1 (address/read/write/wdata/rdata/resp)
//  pmem_address out  s_addr  latched address of the granted client
//  pmem_read    out  1       line read to memory
//  pmem_write   out  1       line write to memory
//  pmem_wdata   out  s_line  latched write line
//  pmem_rdata   in   s_line  line from memory
//  pmem_resp    in   1       memory transaction complete
// BEHAVIOUR
//  Reset: state IDLE; pmem_read/pmem_write/c0_resp/c1_resp = 0;
//   pmem_address/pmem_wdata = 0; rr pointer = RR_INIT.
//  States: IDLE -> BUSY -> RELEASE -> IDLE.
//  IDLE: req_x = cx_read | cx_write.
//   - One client requesting: grant it.
//   - Both requesting: grant the client the rr pointer favours; the pointer then
//     flips to the other client.
//   - On grant edge: latch owner, address, wdata and op (write wins if read&write both
//     high), then go to BUSY.
//   - pmem_read/pmem_write assert from the cycle after the request is first seen
//     (1-cycle arbitration latency).
//  BUSY: hold latched command and ignore all new requests.
//   - On pmem_resp: pulse owner's cx_resp combinationally in that same cycle.
//   - Same edge: deassert pmem_read/pmem_write and go to RELEASE.
//  RELEASE: one dead cycle so the owner can drop its request; no grant is made. -> IDLE.
//   - Back-to-back requests from one client therefore see a >=2-cycle gap.
//  c0_rdata = c1_rdata = pmem_rdata always; only the resp strobe qualifies the data.
//  Non-owner resp is never asserted.
//  Owner withdraws its request while BUSY: the memory transaction still completes,
//   cx_resp is suppressed, and the FSM goes to RELEASE as usual.
//  pmem_resp in IDLE or RELEASE: ignored.
//  Async reset mid-transaction: immediate return to reset values; the in-flight
//   memory access is abandoned.
//  No starvation: a client waiting in IDLE is granted within one transaction of the
//   other client.
// STRUCTURE
//  Shared package arb_pkg:
//   - typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t
//   - typedef enum logic {CLIENT_I=0, CLIENT_D=1} arb_client_t
//   - localparam S_LINE = 256
//  Sub-module rr_pick2 (combinational): req[1:0] + pointer -> one-hot grant, next pointer.
//  Top level holds the FSM, the command latch and the output muxing.
// TESTING
//  1. c0_read, addr 0x0000_0040, alone
//     -> pmem_read=1 next cycle with pmem_address=0x40;
//        pmem_resp returning 0xA5..A5 -> c0_resp 1 cycle, c0_rdata=0xA5..A5, c1_resp=0.
//  2. c0_read and c1_write (addr 0x80, wdata 0x1234..) same cycle after reset, RR_INIT=0
//     -> c0 served first, then c1 with pmem_write=1 and pmem_wdata=0x1234..;
//        next contention grants c0 again.
//  3. c1 changes c1_address to 0xFFFF_FFE0 while BUSY on 0x80
//     -> pmem_address stays 0x80 until pmem_resp.
//  4. rst low while BUSY -> same cycle: pmem_read=0, resp=0, state IDLE;
//     after release, a fresh request is granted normally.
//  5. c0 drops its request mid-BUSY -> c0_resp never pulses;
//     a pending c1 is granted after RELEASE.
//  6. c0 and c1 both continuously requesting for 10 transactions -> grants alternate 0,1,0,1...

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state, client id and line-width constants for the pmem arbiter
package arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;
  typedef enum logic {CLIENT_I = 1'b0, CLIENT_D = 1'b1} arb_client_t;
  localparam int S_LINE = 256;
  localparam int S_ADDR = 32;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; req/ptr in, one-hot gnt and next pointer out
//   req     in  2  request per client
//   ptr     in  1  client favoured when both request
//   gnt     out 2  one-hot grant (zero when nobody requests)
//   ptr_nxt out 1  pointer after this pick: favours the client that lost
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);
  always_comb begin
    gnt = &req ? (ptr ? 2'b10 : 2'b01) : req;
    ptr_nxt = |req ? ~gnt[1] : ptr;
  end
endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one line-wide physical memory port between icache (c0) and dcache (c1)
//   clk, rst                 clock; asynchronous active-low reset
//   c0_*/c1_* address/read/write/wdata in, rdata/resp out: client line ports
//   pmem_address/read/write/wdata out, pmem_rdata/resp in: memory port
module pmem_arbiter
  import arb_pkg::*;
#(
  parameter int   s_line  = S_LINE,
  parameter int   s_addr  = S_ADDR,
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] c0_address,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [s_line-1:0] c0_wdata,
  output logic [s_line-1:0] c0_rdata,
  output logic              c0_resp,
  input  logic [s_addr-1:0] c1_address,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [s_line-1:0] c1_wdata,
  output logic [s_line-1:0] c1_rdata,
  output logic              c1_resp,
  output logic [s_addr-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  arb_state_t  state;
  arb_client_t owner;
  logic [1:0]  req, gnt;
  logic        ptr, ptr_nxt, sel;
  assign req = {c1_read | c1_write, c0_read | c0_write};
  assign sel = gnt[1];
  rr_pick2 u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= CLIENT_I;
      ptr          <= RR_INIT;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          state        <= BUSY;
          owner        <= arb_client_t'(sel);
          ptr          <= ptr_nxt;
          pmem_address <= sel ? c1_address : c0_address;
          pmem_wdata   <= sel ? c1_wdata : c0_wdata;
          // write wins when a client raises read and write together
          pmem_write   <= sel ? c1_write : c0_write;
          pmem_read    <= sel ? c1_read & ~c1_write : c0_read & ~c0_write;
        end
        BUSY: if (pmem_resp) begin
          state      <= RELEASE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // the owner only sees resp if it is still asking; a withdrawn request completes silently
  assign c0_resp  = state == BUSY && pmem_resp && owner == CLIENT_I && req[0];
  assign c1_resp  = state == BUSY && pmem_resp && owner == CLIENT_D && req[1];
  assign c0_rdata = pmem_rdata;
  assign c1_rdata = pmem_rdata;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of grant, latching, round-robin, withdraw and async reset
module tb_pmem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  c0_address, c1_address, pmem_address;
  logic         c0_read, c0_write, c1_read, c1_write, c0_resp, c1_resp;
  logic [255:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;
  int           passed = 0, total = 0;
  logic [255:0] a5 = {32{8'hA5}};
  logic [255:0] w12 = {16{16'h1234}};
  always #5 clk = ~clk;
  pmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .c0_address   (c0_address),
    .c0_read      (c0_read),
    .c0_write     (c0_write),
    .c0_wdata     (c0_wdata),
    .c0_rdata     (c0_rdata),
    .c0_resp      (c0_resp),
    .c1_address   (c1_address),
    .c1_read      (c1_read),
    .c1_write     (c1_write),
    .c1_wdata     (c1_wdata),
    .c1_rdata     (c1_rdata),
    .c1_resp      (c1_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // memory answers in the current cycle; returns just after the edge that leaves BUSY
  task automatic respond(input string tag, input logic [1:0] exp);
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    check(tag, {c1_resp, c0_resp}, exp);
    cyc();
    pmem_resp = 1'b0;
  endtask
  initial begin
    rst = 1'b0;
    {c0_read, c0_write, c1_read, c1_write, pmem_resp} = '0;
    c0_address = '0; c1_address = '0; c0_wdata = '0; c1_wdata = '0; pmem_rdata = '0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_rd", pmem_read, 1'b0);
    check("rst_wr", pmem_write, 1'b0);
    check("rst_addr", pmem_address, 0);
    check("rst_wdata", pmem_wdata, 0);
    check("rst_resp", {c1_resp, c0_resp}, 0);
    cyc();
    rst = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    check("idle_resp_ignored", {c1_resp, c0_resp}, 0);
    cyc();
    pmem_resp = 1'b0;
    // lone icache read
    c0_address = 32'h40; c0_read = 1'b1;
    @(negedge clk);
    check("t1_no_early_rd", pmem_read, 1'b0);
    cyc();
    @(negedge clk);
    check("t1_rd", pmem_read, 1'b1);
    check("t1_addr", pmem_address, 32'h40);
    pmem_rdata = a5;
    respond("t1_resp", 2'b01);
    check("t1_rdata", c0_rdata, a5);
    c0_read = 1'b0;
    @(negedge clk);
    check("t1_rd_drop", pmem_read, 1'b0);
    cyc();
    // contention right after reset
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    c0_address = 32'h100; c0_read = 1'b1;
    c1_address = 32'h80; c1_write = 1'b1; c1_wdata = w12;
    cyc();
    @(negedge clk);
    check("t2_c0_addr", pmem_address, 32'h100);
    check("t2_c0_op", {pmem_write, pmem_read}, 2'b01);
    respond("t2_c0_resp", 2'b01);
    c0_read = 1'b0;
    cyc();
    @(negedge clk);
    check("t2_release_gap", {pmem_write, pmem_read}, 2'b00);
    cyc();
    @(negedge clk);
    check("t2_c1_op", {pmem_write, pmem_read}, 2'b10);
    check("t2_c1_addr", pmem_address, 32'h80);
    check("t2_c1_wdata", pmem_wdata, w12);
    c1_address = 32'hFFFF_FFE0;
    cyc();
    @(negedge clk);
    check("t3_addr_held", pmem_address, 32'h80);
    respond("t2_c1_resp", 2'b10);
    c1_write = 1'b0;
    cyc();
    c0_address = 32'h100; c0_read = 1'b1;
    c1_address = 32'h180; c1_read = 1'b1;
    cyc();
    @(negedge clk);
    check("t2_rr_c0_again", pmem_address, 32'h100);
    // async reset mid-transaction
    rst = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("t4_rd", pmem_read, 1'b0);
    check("t4_resp", {c1_resp, c0_resp}, 0);
    check("t4_addr", pmem_address, 0);
    pmem_resp = 1'b0;
    c0_read = 1'b0; c1_read = 1'b0;
    cyc();
    rst = 1'b1;
    c1_address = 32'h200; c1_read = 1'b1;
    cyc();
    @(negedge clk);
    check("t4_fresh_rd", pmem_read, 1'b1);
    check("t4_fresh_addr", pmem_address, 32'h200);
    respond("t4_fresh_resp", 2'b10);
    c1_read = 1'b0;
    cyc();
    // owner withdraws while busy
    c0_address = 32'h300; c0_read = 1'b1;
    c1_address = 32'h400; c1_read = 1'b1;
    cyc();
    c0_read = 1'b0;
    @(negedge clk);
    check("t5_addr", pmem_address, 32'h300);
    respond("t5_suppressed", 2'b00);
    @(negedge clk);
    check("t5_rd_drop", pmem_read, 1'b0);
    cyc();
    cyc();
    @(negedge clk);
    check("t5_c1_addr", pmem_address, 32'h400);
    check("t5_c1_rd", pmem_read, 1'b1);
    respond("t5_c1_resp", 2'b10);
    // sustained contention alternates
    c0_address = 32'h500; c0_read = 1'b1;
    c1_address = 32'h600;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      @(negedge clk);
      check($sformatf("t6_addr%0d", i), pmem_address, (i % 2) ? 32'h600 : 32'h500);
      respond($sformatf("t6_resp%0d", i), (i % 2) ? 2'b10 : 2'b01);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
